// File: rtl/msk_aes_input_loader.sv
// Input loader for the masked AES core: collects share-major 32-bit words of
// plaintext and key and presents them in the core's bit-interleaved shbus layout.
module msk_aes_input_loader #(
  parameter int d               = 2,
  parameter int WORDS_PER_SHARE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic             in_key_reuse,
  input  logic             in_inverse,
  output logic [128*d-1:0] sh_plaintext,
  output logic [128*d-1:0] sh_key,
  output logic             out_inverse,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             pkt_error,
  output logic [1:0]       dbg_state,
  output logic             dbg_key_loaded
);

  // Handshake: a word moves when in_valid & in_ready at a rising clk edge; the
  // assembled block moves to the core when out_valid & out_ready at an edge.
  // Producers must hold their data stable until the transfer happens.

  localparam int PT_WORDS = WORDS_PER_SHARE * d;
  localparam int CW       = $clog2(8 * d);
  localparam int IW       = CW - 1;
  localparam logic [CW-1:0] PT_LAST  = CW'(PT_WORDS - 1);
  localparam logic [CW-1:0] KEY_BASE = CW'(PT_WORDS);
  localparam logic [CW-1:0] KEY_LAST = CW'(2 * PT_WORDS - 1);

  typedef enum logic [1:0] {
    LOAD_PT  = 2'd0,
    LOAD_KEY = 2'd1,
    FULL     = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic            key_loaded;
  logic            reuse_q;
  logic [128*d-1:0] pt_buf;
  logic [128*d-1:0] key_buf;

  logic          accept;
  logic          reuse_eff;
  logic          pkt_done;
  logic          early_last;
  logic          pt_we;
  logic          key_we;
  logic [IW-1:0] pt_idx;
  logic [IW-1:0] key_idx;

  // Reuse is decided on the first word; later words use the latched decision.
  assign accept     = in_valid & in_ready;
  assign reuse_eff  = (count == '0) ? (in_key_reuse & key_loaded) : reuse_q;
  assign pkt_done   = ((state == LOAD_PT) && (count == PT_LAST) && reuse_eff) ||
                      ((state == LOAD_KEY) && (count == KEY_LAST));
  assign early_last = accept & in_last & ~pkt_done;
  assign pt_we      = accept & (state == LOAD_PT) & ~early_last;
  assign key_we     = accept & (state == LOAD_KEY) & ~early_last;
  assign pt_idx     = count[IW-1:0];
  assign key_idx    = IW'(count - KEY_BASE);

  assign dbg_state      = state;
  assign dbg_key_loaded = key_loaded;

  for (genvar w = 0; w < PT_WORDS; w++) begin : g_words
    logic [31:0] pt_word;
    logic [31:0] key_word;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pt_word  <= '0;
        key_word <= '0;
      end else begin
        if (pt_we && (pt_idx == IW'(w)))
          pt_word <= in_data;
        if (key_we && (key_idx == IW'(w)))
          key_word <= in_data;
      end
    end

    assign pt_buf[32*w +: 32]  = pt_word;
    assign key_buf[32*w +: 32] = key_word;
  end

  // Storage bit b of share j lands on shbus bit d*b+j.
  for (genvar j = 0; j < d; j++) begin : g_share
    for (genvar b = 0; b < 128; b++) begin : g_bit
      assign sh_plaintext[d*b+j] = pt_buf[128*j+b];
      assign sh_key[d*b+j]       = key_buf[128*j+b];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= LOAD_PT;
      count       <= '0;
      key_loaded  <= 1'b0;
      reuse_q     <= 1'b0;
      out_inverse <= 1'b0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      pkt_error   <= 1'b0;
    end else begin
      pkt_error <= 1'b0;
      unique case (state)
        LOAD_PT, LOAD_KEY: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (early_last) begin
              // Drop the word and restart framing; a half-written key is unusable.
              pkt_error <= 1'b1;
              count     <= '0;
              state     <= LOAD_PT;
              if (state == LOAD_KEY)
                key_loaded <= 1'b0;
            end else begin
              count <= count + 1'b1;
              if (count == '0) begin
                reuse_q     <= in_key_reuse & key_loaded;
                out_inverse <= in_inverse;
              end
              if (pkt_done) begin
                state     <= FULL;
                in_ready  <= 1'b0;
                out_valid <= 1'b1;
                pkt_error <= ~in_last;
                if (state == LOAD_KEY)
                  key_loaded <= 1'b1;
              end else if ((state == LOAD_PT) && (count == PT_LAST)) begin
                state <= LOAD_KEY;
              end
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            state     <= LOAD_PT;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            count     <= '0;
          end
        end
        default: begin
          state <= LOAD_PT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msk_aes_input_loader.sv
// Directed bench for msk_aes_input_loader with d=2: framing, key reuse,
// back-pressure, framing errors and asynchronous reset.
module tb_msk_aes_input_loader;

  localparam int D = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [31:0]    in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           in_last = 1'b0;
  logic           in_key_reuse = 1'b0;
  logic           in_inverse = 1'b0;
  logic [128*D-1:0] sh_plaintext;
  logic [128*D-1:0] sh_key;
  logic           out_inverse;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic           pkt_error;
  logic [1:0]     dbg_state;
  logic           dbg_key_loaded;

  int checks = 0;
  int passed = 0;

  localparam logic [127:0] P1 = 128'he0370734_313198a2_885a308d_3243f6a8;
  localparam logic [127:0] K1 = 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516;
  localparam logic [127:0] A  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] B  = 128'hdeadbeef_01234567_89abcdef_0f1e2d3c;
  localparam logic [127:0] P5A = 128'hffffffff_00000000_ffffffff_00000000;
  localparam logic [127:0] P5B = 128'h0f0f0f0f_f0f0f0f0_12345678_9abcdef0;
  localparam logic [127:0] K5A = 128'h13579bdf_2468ace0_fdb97531_0eca8642;
  localparam logic [127:0] K5B = 128'h55555555_aaaaaaaa_33333333_cccccccc;

  msk_aes_input_loader #(.d(D), .WORDS_PER_SHARE(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_last        (in_last),
    .in_key_reuse   (in_key_reuse),
    .in_inverse     (in_inverse),
    .sh_plaintext   (sh_plaintext),
    .sh_key         (sh_key),
    .out_inverse    (out_inverse),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .pkt_error      (pkt_error),
    .dbg_state      (dbg_state),
    .dbg_key_loaded (dbg_key_loaded)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Recover share j from the interleaved bus: share bit b sits at bus bit 2b+j.
  function automatic logic [127:0] unshuf(input logic [255:0] sh, input int j);
    logic [127:0] r;
    for (int b = 0; b < 128; b++) r[b] = sh[2*b+j];
    return r;
  endfunction

  // driver tasks
  task automatic send_word(input logic [31:0] data, input logic last,
                           input logic reuse, input logic inv);
    int n;
    n = 0;
    in_data = data; in_valid = 1'b1; in_last = last;
    in_key_reuse = reuse; in_inverse = inv;
    while (in_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_wait", 256'(n >= 200), 256'(0));
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_packet(input logic [127:0] p0, input logic [127:0] p1,
                             input logic [127:0] k0, input logic [127:0] k1,
                             input logic reuse, input logic inv,
                             input int first, input int nwords, input int last_at);
    logic [31:0] w;
    for (int i = first; i < nwords; i++) begin
      if (i < 4)       w = 32'(p0 >> (32*i));
      else if (i < 8)  w = 32'(p1 >> (32*(i-4)));
      else if (i < 12) w = 32'(k0 >> (32*(i-8)));
      else             w = 32'(k1 >> (32*(i-12)));
      send_word(w, (i == last_at), (i == 0) ? reuse : ~reuse, (i == 0) ? inv : ~inv);
    end
  endtask

  task automatic do_transfer(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_xfer_valid"}, 256'(out_valid), 256'(0));
    check({tag, "_xfer_ready"}, 256'(in_ready), 256'(1));
  endtask

  initial begin
    logic bp_ok;

    // reset values
    #1 rst = 1'b0;
    #11;
    check("rst_in_ready", 256'(in_ready), 256'(0));
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_pkt_error", 256'(pkt_error), 256'(0));
    check("rst_inverse", 256'(out_inverse), 256'(0));
    check("rst_pt", 256'(sh_plaintext), 256'(0));
    check("rst_key", 256'(sh_key), 256'(0));
    check("rst_state", 256'(dbg_state), 256'(0));
    check("rst_key_loaded", 256'(dbg_key_loaded), 256'(0));
    @(posedge clk); #1 rst = 1'b1;
    check("rel_ready_low", 256'(in_ready), 256'(0));
    @(posedge clk); #1;
    check("rel_ready_high", 256'(in_ready), 256'(1));

    // full 16-word packet, FIPS-197 example data in share 0
    send_packet(P1, '0, K1, '0, 1'b0, 1'b0, 0, 15, 15);
    check("t1_valid_early", 256'(out_valid), 256'(0));
    send_packet(P1, '0, K1, '0, 1'b0, 1'b0, 15, 16, 15);
    check("t1_valid", 256'(out_valid), 256'(1));
    check("t1_ready", 256'(in_ready), 256'(0));
    check("t1_pt0", 256'(unshuf(sh_plaintext, 0)), 256'(P1));
    check("t1_pt1", 256'(unshuf(sh_plaintext, 1)), 256'(0));
    check("t1_key0", 256'(unshuf(sh_key, 0)), 256'(K1));
    check("t1_key1", 256'(unshuf(sh_key, 1)), 256'(0));
    check("t1_pt_lo16", 256'(sh_plaintext[15:0]), 256'(16'h4440));
    check("t1_key_lo16", 256'(sh_key[15:0]), 256'(16'h0114));
    check("t1_inverse", 256'(out_inverse), 256'(0));
    check("t1_key_loaded", 256'(dbg_key_loaded), 256'(1));
    check("t1_err", 256'(pkt_error), 256'(0));
    do_transfer("t1");

    // key reuse: 8 words, flags only on the first word
    send_packet(A, B, '0, '0, 1'b1, 1'b1, 0, 8, 7);
    check("t2_valid", 256'(out_valid), 256'(1));
    check("t2_pt0", 256'(unshuf(sh_plaintext, 0)), 256'(A));
    check("t2_pt1", 256'(unshuf(sh_plaintext, 1)), 256'(B));
    check("t2_key0", 256'(unshuf(sh_key, 0)), 256'(K1));
    check("t2_key1", 256'(unshuf(sh_key, 1)), 256'(0));
    check("t2_inverse", 256'(out_inverse), 256'(1));
    check("t2_pt_lo16", 256'(sh_plaintext[15:0]), 256'(16'h5ff5));

    // back-pressure for 50 cycles with a word offered at the input
    bp_ok = 1'b1;
    in_valid = 1'b1; in_data = 32'hcafef00d;
    repeat (50) begin
      @(posedge clk); #1;
      bp_ok &= (out_valid === 1'b1) && (in_ready === 1'b0) &&
               (unshuf(sh_plaintext, 0) === A) && (unshuf(sh_plaintext, 1) === B) &&
               (unshuf(sh_key, 0) === K1) && (out_inverse === 1'b1);
    end
    in_valid = 1'b0;
    check("bp_hold", 256'(bp_ok), 256'(1));
    do_transfer("bp");

    // early in_last on word 5
    send_packet(P5A, P5B, K5A, K5B, 1'b0, 1'b0, 0, 5, 4);
    check("t3_err_pulse", 256'(pkt_error), 256'(1));
    check("t3_no_valid", 256'(out_valid), 256'(0));
    check("t3_state", 256'(dbg_state), 256'(0));
    check("t3_key_kept", 256'(dbg_key_loaded), 256'(1));
    @(posedge clk); #1;
    check("t3_err_single", 256'(pkt_error), 256'(0));
    send_packet(P5A, P5B, K5A, K5B, 1'b0, 1'b0, 0, 16, 15);
    check("t3_valid", 256'(out_valid), 256'(1));
    check("t3_pt0", 256'(unshuf(sh_plaintext, 0)), 256'(P5A));
    check("t3_pt1", 256'(unshuf(sh_plaintext, 1)), 256'(P5B));
    check("t3_key0", 256'(unshuf(sh_key, 0)), 256'(K5A));
    check("t3_key1", 256'(unshuf(sh_key, 1)), 256'(K5B));
    check("t3_ok_err", 256'(pkt_error), 256'(0));
    do_transfer("t3");

    // final word without in_last: accepted, flagged
    send_packet(P1, '0, K1, '0, 1'b0, 1'b0, 0, 16, -1);
    check("t4_valid", 256'(out_valid), 256'(1));
    check("t4_err_pulse", 256'(pkt_error), 256'(1));
    check("t4_pt0", 256'(unshuf(sh_plaintext, 0)), 256'(P1));
    @(posedge clk); #1;
    check("t4_err_single", 256'(pkt_error), 256'(0));
    check("t4_still_valid", 256'(out_valid), 256'(1));
    do_transfer("t4");

    // asynchronous reset during LOAD_KEY
    send_packet(A, B, K5A, K5B, 1'b0, 1'b1, 0, 10, -1);
    check("t5_in_key", 256'(dbg_state), 256'(1));
    #3 rst = 1'b0;
    #1;
    check("t5_rst_valid", 256'(out_valid), 256'(0));
    check("t5_rst_key_loaded", 256'(dbg_key_loaded), 256'(0));
    check("t5_rst_ready", 256'(in_ready), 256'(0));
    check("t5_rst_state", 256'(dbg_state), 256'(0));
    check("t5_rst_key", 256'(sh_key), 256'(0));
    @(posedge clk); #1 rst = 1'b1;
    send_packet(A, B, K1, '0, 1'b1, 1'b0, 0, 8, -1);
    check("t5_reuse_ignored", 256'(out_valid), 256'(0));
    check("t5_state_key", 256'(dbg_state), 256'(1));
    send_packet(A, B, K1, '0, 1'b1, 1'b0, 8, 16, 15);
    check("t5_valid", 256'(out_valid), 256'(1));
    check("t5_pt0", 256'(unshuf(sh_plaintext, 0)), 256'(A));
    check("t5_key0", 256'(unshuf(sh_key, 0)), 256'(K1));
    check("t5_key_loaded", 256'(dbg_key_loaded), 256'(1));
    do_transfer("t5");

    // final report
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/msk_aes_input_loader.md
Name: msk_aes_input_loader

Overview:
Upstream stage of MSKaes_32bits_core. Receives share-major 32-bit words of a masked plaintext and key and assembles them into the core's bit-interleaved shbus layout. Presents them with a valid/ready handshake on the core's valid_in/in_ready. Supports key reuse, so a new block can be loaded without re-sending the key shares.

Parameters:
d, 2, number of shares (>=2)
WORDS_PER_SHARE, 4, 32-bit words per 128-bit share (fixed at 4; not meant to be overridden)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous, active-low reset
in_data  input  32  share word
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts a word this cycle
in_last  input  1  marks the final word of a packet
in_key_reuse  input  1  sampled with the first word of a packet: packet carries plaintext only
in_inverse  input  1  sampled with the first word of a packet: decryption request
sh_plaintext  output  128*d  shbus-encoded plaintext shares
sh_key  output  128*d  shbus-encoded key shares
out_inverse  output  1  latched inverse flag for the core
out_valid  output  1  drives core valid_in
out_ready  input  1  core in_ready
pkt_error  output  1  one-cycle pulse on a malformed packet

Behaviour:
- Reset (rst=0, asynchronous): state=LOAD_PT, word counter=0, key_loaded=0, out_valid=0, in_ready=0 until first clk edge after release, pkt_error=0, out_inverse=0, sh_plaintext=0, sh_key=0.
- Word order in a packet: plaintext share 0 words 0..3, share 1 words 0..3, ..., share d-1; then key shares in the same order unless key reuse.
- Word k of share j holds share-major bits [32k+31:32k] of share j.
- Storage bit b of share j maps to shbus bit d*b+j.
- Packet length: 4*d words if key reuse, else 8*d words.
- Key-reuse eligibility: key reuse applies only when key_loaded=1. Otherwise in_key_reuse is ignored and a full packet is expected.
- Counter: 0..8*d-1, ceil(log2(8*d))-bit; increments on each accepted word (in_valid & in_ready).
- States:
  - LOAD_PT: accepts words into the plaintext buffer. On the last plaintext word, go to FULL if key reuse, else to LOAD_KEY.
  - LOAD_KEY: accepts words into the key buffer. On the last key word, set key_loaded=1 and go to FULL.
  - FULL: in_ready=0, out_valid=1. When out_valid & out_ready: out_valid=0, counter=0, go to LOAD_PT.
- in_ready is registered: 1 in LOAD_PT and LOAD_KEY, 0 in FULL. out_valid=1 exactly in FULL.
- Latency: out_valid rises the cycle after the final word is accepted. No new word is accepted in the same cycle as the output transfer; in_ready returns 1 the cycle after.
- While out_valid=1, sh_plaintext, sh_key and out_inverse are held stable.
- Flags: in_key_reuse and in_inverse are sampled only on a packet's first accepted word (counter=0). out_inverse is updated at that point.
- Framing errors:
  - in_last=1 on a non-final word: that word is dropped, pkt_error pulses, counter returns to 0, state returns to LOAD_PT. Partially written plaintext and key are discarded logically.
  - If the error occurs during LOAD_KEY, key_loaded is cleared to 0, because the key buffer is corrupted.
  - Final word with in_last=0: accepted normally, pkt_error pulses, state still goes to FULL.
- Reset mid-packet or while FULL clears all state immediately. No output transfer completes.

Test Plan:
- d=2, full packet of 16 words: plaintext 32 43 f6 a8 88 5a 30 8d 31 31 98 a2 e0 37 07 34 as share 0, share 1 all zero; key 2b 7e 15 16 28 ae d2 a6 ab f7 15 88 09 cf 4f 3c as share 0, share 1 zero; out_ready=1 -> out_valid one cycle after word 16. Core output recombines to 39 25 84 1d 02 dc 09 fb dc 11 85 97 19 6a 0b 32.
- Key reuse after the test 1 key: 8-word packet with in_key_reuse=1 -> out_valid after 8 words, sh_key unchanged.
- Key reuse right after reset -> in_key_reuse ignored; out_valid only after 16 words.
- in_last=1 on word 5 -> pkt_error single pulse, no out_valid. A following well-formed 16-word packet yields a correct output.
- Back-pressure: hold out_ready=0 for 50 cycles in FULL -> in_ready=0, outputs stable throughout; transfer on the first out_ready=1 cycle.
- Assert rst=0 asynchronously mid-LOAD_KEY -> out_valid=0 and key_loaded=0 immediately. A subsequent key-reuse request is treated as a full packet.
